// File: rtl/eth_tx_pkg.sv
// Shared definitions for the Ethernet transmit path: the transmit
// arbiter (eth_tx_arb) and the eth_tx MAC both import this package.
package eth_tx_pkg;

    localparam int SIZE_W         = 11;
    localparam int PAKET_MAX_SIZE = 1500;
    localparam int GAP_CYCLES     = 1000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } tx_state_e;

    // A packet size is usable only when it is non-zero and fits the MAC limit.
    function automatic logic size_is_legal(input int unsigned size,
                                           input int unsigned max_size);
        return (size != 0) && (size <= max_size);
    endfunction

    // Durations of zero collapse to a single cycle so the FSM always advances.
    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

endpackage

// File: rtl/eth_tx_arb_if.sv
// Bundle of the arbiter's request, grant and eth_tx handshake signals.
// The master side is the requesters plus the MAC; the slave side is the arbiter.
interface eth_tx_arb_if #(
    parameter int N_REQ  = 2,
    parameter int SIZE_W = eth_tx_pkg::SIZE_W
);

    logic [N_REQ-1:0]  i_req;
    logic [SIZE_W-1:0] i_size0;
    logic [SIZE_W-1:0] i_size1;
    logic              i_tx_ready;

    logic [N_REQ-1:0]  o_grant;
    logic [N_REQ-1:0]  o_done;
    logic [N_REQ-1:0]  o_err;
    logic              o_tx_en;
    logic [SIZE_W-1:0] o_tx_size;
    logic              o_ram_sel;
    logic              o_busy;
    logic              o_led_tx;

    modport master (
        output i_req, i_size0, i_size1, i_tx_ready,
        input  o_grant, o_done, o_err, o_tx_en, o_tx_size, o_ram_sel, o_busy, o_led_tx
    );

    modport slave (
        input  i_req, i_size0, i_size1, i_tx_ready,
        output o_grant, o_done, o_err, o_tx_en, o_tx_size, o_ram_sel, o_busy, o_led_tx
    );

endinterface

// File: rtl/eth_tx_arb_rr_arb.sv
// Round-robin selector: searches requests starting just after the
// last-granted index and returns the first hit as one-hot plus index.
module rr_arb #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // Walk the requesters in rotating order and keep the first one asking.
    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(pointer) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/eth_tx_arb.sv
// Transmit arbiter: hands the single eth_tx MAC and its RAM bank to one
// requester at a time, fires the start pulse, tracks the MAC's ready
// handshake and enforces an idle gap between packets.
module eth_tx_arb #(
    parameter int N_REQ          = 2,
    parameter int SIZE_W         = eth_tx_pkg::SIZE_W,
    parameter int PAKET_MAX_SIZE = eth_tx_pkg::PAKET_MAX_SIZE,
    parameter int GAP_CYCLES     = eth_tx_pkg::GAP_CYCLES,
    parameter int START_TIMEOUT  = 16
) (
    input logic         i_clk,
    input logic         i_rst_n,
    eth_tx_arb_if.slave bus
);

    import eth_tx_pkg::*;

    localparam int IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_LEN = at_least_one(GAP_CYCLES);
    localparam int GAP_W   = $clog2(GAP_LEN + 1);
    localparam int TO_LEN  = at_least_one(START_TIMEOUT);
    localparam int TO_W    = $clog2(TO_LEN + 1);

    tx_state_e         state_q,   state_d;
    logic [N_REQ-1:0]  grant_q,   grant_d;
    logic [N_REQ-1:0]  done_q,    done_d;
    logic [N_REQ-1:0]  err_q,     err_d;
    logic              tx_en_q,   tx_en_d;
    logic [SIZE_W-1:0] tx_size_q, tx_size_d;
    logic [IDX_W-1:0]  ram_sel_q, ram_sel_d;
    logic              led_q,     led_d;
    logic [IDX_W-1:0]  ptr_q,     ptr_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,  to_cnt_d;

    logic [N_REQ-1:0]  rr_grant;
    logic [IDX_W-1:0]  rr_index;
    logic [SIZE_W-1:0] win_size;
    logic              win_legal;

    rr_arb #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .req     (bus.i_req),
        .pointer (ptr_q),
        .grant   (rr_grant),
        .index   (rr_index)
    );

    assign win_size  = (rr_index == '0) ? bus.i_size0 : bus.i_size1;
    assign win_legal = size_is_legal(32'(win_size), 32'(PAKET_MAX_SIZE));

    // Next-state and registered-output logic; pulses default low, the rest hold.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        done_d    = '0;
        err_d     = '0;
        tx_en_d   = 1'b0;
        tx_size_d = tx_size_q;
        ram_sel_d = ram_sel_q;
        led_d     = led_q;
        ptr_d     = ptr_q;
        gap_cnt_d = gap_cnt_q;
        to_cnt_d  = to_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if ((|bus.i_req) && bus.i_tx_ready) begin
                    ptr_d     = rr_index;
                    gap_cnt_d = '0;
                    if (win_legal) begin
                        grant_d   = rr_grant;
                        ram_sel_d = rr_index;
                        tx_size_d = win_size;
                        tx_en_d   = 1'b1;
                        led_d     = 1'b1;
                        state_d   = ST_START;
                    end else begin
                        err_d   = rr_grant;
                        state_d = ST_GAP;
                    end
                end
            end

            ST_START: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                if (!bus.i_tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_cnt_q >= TO_W'(TO_LEN - 1)) begin
                    err_d     = grant_q;
                    grant_d   = '0;
                    led_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (to_cnt_q < TO_W'(TO_LEN)) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end

            ST_WAIT_DONE: begin
                if (bus.i_tx_ready) begin
                    done_d    = grant_q;
                    grant_d   = '0;
                    led_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q >= GAP_W'(GAP_LEN - 1)) begin
                    state_d = ST_IDLE;
                end else if (gap_cnt_q < GAP_W'(GAP_LEN)) begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; the pointer resets to the last requester so requester 0 wins the first tie.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            done_q    <= '0;
            err_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_size_q <= '0;
            ram_sel_q <= '0;
            led_q     <= 1'b0;
            ptr_q     <= IDX_W'(N_REQ - 1);
            gap_cnt_q <= '0;
            to_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            err_q     <= err_d;
            tx_en_q   <= tx_en_d;
            tx_size_q <= tx_size_d;
            ram_sel_q <= ram_sel_d;
            led_q     <= led_d;
            ptr_q     <= ptr_d;
            gap_cnt_q <= gap_cnt_d;
            to_cnt_q  <= to_cnt_d;
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_done    = done_q;
    assign bus.o_err     = err_q;
    assign bus.o_tx_en   = tx_en_q;
    assign bus.o_tx_size = tx_size_q;
    assign bus.o_ram_sel = ram_sel_q[0];
    assign bus.o_led_tx  = led_q;
    assign bus.o_busy    = (state_q != ST_IDLE);

endmodule
